disp_line_arb: RTL and testbench

Sequencer and arbiter for a single character-display line. Two producers (for example the binary-view and hex-view formatters) each present a full line of 8-bit character codes. The block grants the line to one producer at a time, round-robin, and snapshots that producer's characters. It then streams one cursor/address command followed by the characters, leftmost first, over a valid/ready byte interface to the LCD driver.

---
 rtl/disp_pkg.sv | 15 +
 rtl/rr_arb2.sv | 17 +
 rtl/disp_line_arb.sv | 132 +++++++++++++
 tb/tb_disp_line_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and state type for the character-display line sequencer.
package disp_pkg;

  localparam logic [7:0] CHAR_0        = 8'h30;
  localparam logic [7:0] CHAR_1        = 8'h31;
  localparam logic [7:0] CHAR_BLANK    = 8'h20;
  localparam logic [7:0] LINE_ADDR_DEF = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } disp_arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the pointer holder wins if requesting, else the other.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req[rr_ptr]) begin
      win[rr_ptr] = 1'b1;
    end else if (req[~rr_ptr]) begin
      win[~rr_ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/disp_line_arb.sv
// Grants one display line to one of two producers, snapshots it, and streams
// the set-cursor command followed by the characters over a valid/ready link.
module disp_line_arb
  import disp_pkg::*;
#(
  parameter int unsigned CHARS     = 20,
  parameter logic [7:0]  LINE_ADDR = LINE_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [CHARS-1:0][7:0] chars0,
  input  logic [CHARS-1:0][7:0] chars1,
  output logic [1:0]            gnt,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_is_cmd
);

  localparam int unsigned IDX_W = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHARS - 1);

  disp_arb_state_t       state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [7:0]            data_q, data_d;
  logic                  is_cmd_q, is_cmd_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic [CHARS-1:0][7:0] buf_q, buf_d;
  logic [1:0]            win;
  logic                  fire;

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .win    (win)
  );

  assign fire = valid_q && out_ready;

  // Next state; output registers are loaded from the state being entered.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = 1'b0;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    buf_d    = buf_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = CMD;
          gnt_d   = win;
          buf_d   = win[1] ? chars1 : chars0;
        end
      end
      CMD: begin
        if (fire) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (fire) begin
          if (idx_q == IDX_LAST) begin
            state_d  = IDLE;
            gnt_d    = 2'b00;
            done_d   = 1'b1;
            rr_ptr_d = ~gnt_q[1];
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    valid_d  = busy_d;
    is_cmd_d = (state_d == CMD);
    data_d   = 8'h00;
    if (state_d == CMD) begin
      data_d = LINE_ADDR;
    end else if (state_d == DATA) begin
      data_d = buf_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      is_cmd_q <= 1'b0;
      idx_q    <= '0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      is_cmd_q <= is_cmd_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Snapshot contents are don't-care after reset, so no reset is applied.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_is_cmd = is_cmd_q;

endmodule

// File: tb/tb_disp_line_arb.sv
// Randomized bench for disp_line_arb against a transaction-level queue model.
module tb_disp_line_arb;
  import disp_pkg::*;

  localparam int unsigned CHARS = 20;
  localparam logic [7:0] LINE_ADDR = 8'h80;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            req;
  logic [CHARS-1:0][7:0] chars0;
  logic [CHARS-1:0][7:0] chars1;
  logic [1:0]            gnt;
  logic                  busy;
  logic                  done;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_data;
  logic                  out_is_cmd;

  disp_line_arb #(.CHARS(CHARS), .LINE_ADDR(LINE_ADDR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .chars0     (chars0),
    .chars1     (chars1),
    .gnt        (gnt),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_is_cmd (out_is_cmd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a line is a queue of {is_cmd, byte} still owed to the driver.
  bit         m_busy;
  bit         m_done;
  bit         m_ptr;
  logic [1:0] m_gnt;
  logic [8:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_ptr  = 1'b0;
    m_gnt  = 2'b00;
    m_q.delete();
  endtask

  // Advance the model over one edge using the inputs now applied, then compare.
  task automatic step();
    int w;
    m_done = 1'b0;
    if (!m_busy) begin
      if (req != 2'b00) begin
        w = req[m_ptr] ? int'(m_ptr) : int'(!m_ptr);
        m_gnt = (w == 1) ? 2'b10 : 2'b01;
        m_q.delete();
        m_q.push_back({1'b1, LINE_ADDR});
        for (int i = 0; i < CHARS; i++)
          m_q.push_back({1'b0, (w == 1) ? chars1[i] : chars0[i]});
        m_busy = 1'b1;
      end
    end else if (out_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_ptr  = (m_gnt == 2'b01);
        m_busy = 1'b0;
        m_gnt  = 2'b00;
        m_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("out_valid", 32'(out_valid), 32'(m_busy));
    if (m_busy) chk("byte", 32'({out_is_cmd, out_data}), 32'(m_q[0]));
    else        chk("idle_byte", 32'({out_is_cmd, out_data}), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_is_cmd", 32'(out_is_cmd), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_done(input int max_cyc, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!done && n < max_cyc);
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic rand_line(input bit which);
    for (int i = 0; i < CHARS; i++) begin
      if (which) chars1[i] = 8'($urandom);
      else       chars0[i] = 8'($urandom);
    end
  endtask

  initial begin
    int cnt;
    clk = 1'b0; rst_n = 1'b0; req = 2'b00; out_ready = 1'b0;
    chars0 = '0; chars1 = '0;
    model_reset();
    do_reset();

    // Single request: blanks then ones, ready tied high.
    for (int i = 0; i < CHARS; i++) chars0[i] = (i < 4) ? CHAR_BLANK : CHAR_1;
    req = 2'b01; out_ready = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (!done && cnt < 40);
    chk("done_latency", 32'(cnt), 32'd22);
    req = 2'b00;
    step();

    // Contention from reset: requester 0 first, then requester 1.
    do_reset();
    rand_line(0); rand_line(1);
    req = 2'b11;
    step();
    chk("cont_first", 32'(gnt), 32'b01);
    run_until_done(60, "cont_done0");
    step();
    chk("cont_second", 32'(gnt), 32'b10);
    req = 2'b00;
    run_until_done(60, "cont_done1");
    step();

    // Backpressure pattern 1,0,0,1 on ready.
    rand_line(0);
    req = 2'b01;
    cnt = 0;
    do begin
      out_ready = (cnt % 4 == 0) || (cnt % 4 == 3);
      step(); cnt++;
    end while (!done && cnt < 200);
    chk("bp_done", 32'(done), 32'd1);
    req = 2'b00; out_ready = 1'b1;
    step();

    // Snapshot: producer overwrites its line right after the grant.
    rand_line(0);
    req = 2'b01;
    step();
    for (int i = 0; i < CHARS; i++) chars0[i] = CHAR_0;
    req = 2'b00;
    run_until_done(40, "snap_done");

    // Request drop at idx 5.
    rand_line(1);
    req = 2'b10;
    repeat (7) step();
    req = 2'b00;
    run_until_done(40, "drop_done");
    step();

    // Reset at idx 10, then requester 1 alone.
    rand_line(0);
    req = 2'b01;
    repeat (12) step();
    do_reset();
    rand_line(1);
    req = 2'b10;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'b10);
    chk("post_rst_cmd", 32'(out_is_cmd), 32'd1);
    req = 2'b00;
    run_until_done(40, "post_rst_done");

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req = 2'($urandom);
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) chars0[$urandom_range(CHARS-1)] = 8'($urandom);
      if ($urandom_range(15) == 0) chars1[$urandom_range(CHARS-1)] = 8'($urandom);
      if ($urandom_range(699) == 0) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
